// File: rtl/repairval_val_pattern_checker.sv
// Receiver-side VALTRAIN pattern checker for MBINIT.REPAIRVAL.
// Serially samples the valid lane, locks onto the repeating 8-bit pattern and
// declares pass after CONSEC_THRESH consecutive aligned matches, or fail when
// the detection window expires.
// Optional macro: REPAIRVAL_ERR_COUNT_EN adds o_mismatch_count (saturating
// count of TRACK iteration mismatches).
module repairval_val_pattern_checker #(
    parameter logic [7:0]  PATTERN       = 8'hF0,
    parameter int unsigned CONSEC_THRESH = 16,
    parameter int unsigned WINDOW_CYCLES = 1088
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       i_enable,
    input  logic       i_rx_val,
    output logic       o_VAL_Result_logged,
    output logic       o_done,
    output logic       o_busy
`ifdef REPAIRVAL_ERR_COUNT_EN
    ,
    output logic [7:0] o_mismatch_count
`endif
);

    localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES + 1);
    localparam int unsigned CON_W = $clog2(CONSEC_THRESH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_TRACK  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state, state_d;
    // Only the previous 7 samples need storing; nxt forms the full 8-bit view.
    logic [6:0]       sr, sr_d;
    logic [7:0]       nxt;
    logic [WIN_W-1:0] win_cnt, win_cnt_d;
    logic [2:0]       phase, phase_d;
    logic [CON_W-1:0] consec, consec_d, consec_inc;
    logic             pass_d;
    logic             match, win_last, chk_point, hit, miss;

    assign nxt        = {sr, i_rx_val};
    assign match      = (nxt == PATTERN);
    assign win_last   = (win_cnt == WIN_W'(WINDOW_CYCLES - 1));
    assign consec_inc = consec + CON_W'(1);
    assign chk_point  = (state == S_TRACK) && (phase == 3'd7);
    assign hit        = chk_point && match && (consec_inc == CON_W'(CONSEC_THRESH));
    assign miss       = chk_point && !match;

    // Next-state and next-value logic for the search/track sequencer
    always_comb begin
        state_d   = state;
        sr_d      = sr;
        win_cnt_d = win_cnt;
        phase_d   = phase;
        consec_d  = consec;
        pass_d    = o_VAL_Result_logged;
        if (!i_enable || (state == S_IDLE)) begin
            sr_d      = '0;
            win_cnt_d = '0;
            phase_d   = '0;
            consec_d  = '0;
            pass_d    = 1'b0;
            state_d   = i_enable ? S_SEARCH : S_IDLE;
        end else begin
            case (state)
                S_SEARCH: begin
                    sr_d      = nxt[6:0];
                    win_cnt_d = win_cnt + WIN_W'(1);
                    if (match && (CONSEC_THRESH == 1)) begin
                        state_d = S_DONE;
                        pass_d  = 1'b1;
                    end else if (win_last) begin
                        state_d = S_DONE;
                    end else if (match) begin
                        state_d  = S_TRACK;
                        consec_d = CON_W'(1);
                        phase_d  = '0;
                    end
                end
                S_TRACK: begin
                    sr_d      = nxt[6:0];
                    win_cnt_d = win_cnt + WIN_W'(1);
                    phase_d   = phase + 3'd1;
                    if (hit) begin
                        state_d  = S_DONE;
                        pass_d   = 1'b1;
                        consec_d = consec_inc;
                    end else if (win_last) begin
                        state_d = S_DONE;
                    end else if (miss) begin
                        state_d  = S_SEARCH;
                        consec_d = '0;
                    end else if (chk_point) begin
                        consec_d = consec_inc;
                    end
                end
                default: ; // S_DONE holds everything while enabled
            endcase
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state               <= S_IDLE;
            sr                  <= '0;
            win_cnt             <= '0;
            phase               <= '0;
            consec              <= '0;
            o_VAL_Result_logged <= 1'b0;
            o_done              <= 1'b0;
            o_busy              <= 1'b0;
        end else begin
            state               <= state_d;
            sr                  <= sr_d;
            win_cnt             <= win_cnt_d;
            phase               <= phase_d;
            consec              <= consec_d;
            o_VAL_Result_logged <= pass_d;
            o_done              <= (state_d == S_DONE);
            o_busy              <= (state_d == S_SEARCH) || (state_d == S_TRACK);
        end
    end

`ifdef REPAIRVAL_ERR_COUNT_EN
    // Saturating count of aligned-iteration mismatches; cleared in IDLE
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            o_mismatch_count <= 8'd0;
        end else if (!i_enable || (state == S_IDLE)) begin
            o_mismatch_count <= 8'd0;
        end else if (miss && (o_mismatch_count != 8'hFF)) begin
            o_mismatch_count <= o_mismatch_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_repairval_val_pattern_checker.sv
// Scoreboard bench for repairval_val_pattern_checker: stimulus pushes the
// expected decision (cycle, result) and a monitor checks it when o_done rises.
module tb_repairval_val_pattern_checker;

    localparam int          WIN = 1088;
    localparam int          TH  = 16;
    localparam logic [7:0]  PAT = 8'hF0;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       i_enable;
    logic       i_rx_val;
    logic       o_VAL_Result_logged;
    logic       o_done;
    logic       o_busy;
`ifdef REPAIRVAL_ERR_COUNT_EN
    logic [7:0] o_mismatch_count;
`endif

    repairval_val_pattern_checker dut (
        .CLK                 (CLK),
        .rst_n               (rst_n),
        .i_enable            (i_enable),
        .i_rx_val            (i_rx_val),
        .o_VAL_Result_logged (o_VAL_Result_logged),
        .o_done              (o_done),
        .o_busy              (o_busy)
`ifdef REPAIRVAL_ERR_COUNT_EN
        ,
        .o_mismatch_count    (o_mismatch_count)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int cyc;
        bit pass;
        int mm;
    } exp_t;

    exp_t sb[$];
    bit   s [1:WIN];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   done_q = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: walk the sample stream; a lock starts a run of aligned 8-sample
    // iterations, any aligned miss drops back to a free search at the next sample.
    function automatic void model(output int d, output bit p, output int mm);
        int consec = 0;
        int lock   = 0;
        d = WIN; p = 1'b0; mm = 0;
        for (int k = 1; k <= WIN; k++) begin
            logic [7:0] w;
            bit m;
            for (int j = 0; j < 8; j++) w[j] = (k - j >= 1) ? s[k-j] : 1'b0;
            m = (w == PAT);
            if (consec == 0) begin
                if (m) begin consec = 1; lock = k; end
            end else if (((k - lock) % 8) == 0) begin
                if (m) consec++;
                else begin
                    consec = 0;
                    mm = (mm < 255) ? mm + 1 : 255;
                end
            end
            if (consec == TH) begin d = k; p = 1'b1; return; end
        end
    endfunction

    function automatic void fill_pattern(input int off);
        for (int k = 1; k <= WIN; k++)
            s[k] = (k <= off) ? 1'b0 : PAT[7 - ((k - off - 1) % 8)];
    endfunction

    function automatic void fill_const(input bit v);
        for (int k = 1; k <= WIN; k++) s[k] = v;
    endfunction

    // Monitor: compare each rising o_done against the oldest expectation
    always @(negedge CLK) begin
        exp_t e;
        if (rst_n && o_done && !done_q) begin
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("result", int'(o_VAL_Result_logged), int'(e.pass));
`ifdef REPAIRVAL_ERR_COUNT_EN
                chk("mismatch_count", int'(o_mismatch_count), e.mm);
`endif
            end
        end
        done_q = o_done;
    end

    // One enable session: abort_at = samples before i_enable drops (if no decision
    // yet); dir_d > 0 overrides the model's decision sample with a directed value.
    task automatic run(input int abort_at, input int dir_d, input bit dir_p);
        int d, mm, start, cnt;
        bit p;
        model(d, p, mm);
        if (dir_d > 0) begin d = dir_d; p = dir_p; end
        i_enable = 1'b1;
        i_rx_val = 1'($urandom);
        @(posedge CLK); #1;
        start = cyc;
        if (d <= abort_at) begin
            sb.push_back('{start + d, p, mm});
            cnt = d + 3;
        end else begin
            cnt = abort_at;
        end
        for (int k = 1; k <= cnt; k++) begin
            i_rx_val = (k <= WIN) ? s[k] : 1'($urandom);
            if (k == 1) chk("busy_running", int'(o_busy), 1);
            @(posedge CLK); #1;
        end
        if (d <= abort_at) begin
            chk("done_held", int'(o_done), 1);
            chk("result_held", int'(o_VAL_Result_logged), int'(p));
            chk("busy_after_done", int'(o_busy), 0);
        end
        i_enable = 1'b0;
        i_rx_val = 1'($urandom);
        @(posedge CLK); #1;
        chk("idle_done", int'(o_done), 0);
        chk("idle_busy", int'(o_busy), 0);
        chk("idle_result", int'(o_VAL_Result_logged), 0);
`ifdef REPAIRVAL_ERR_COUNT_EN
        chk("idle_mismatch", int'(o_mismatch_count), 0);
`endif
        repeat ($urandom_range(0, 3)) begin
            i_rx_val = 1'($urandom);
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        int off;
        rst_n    = 1'b0;
        i_enable = 1'b0;
        i_rx_val = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_done", int'(o_done), 0);
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_result", int'(o_VAL_Result_logged), 0);
        rst_n = 1'b1;
        // Pattern toggling while disabled must be ignored
        for (int k = 0; k < 12; k++) begin
            i_rx_val = PAT[7 - (k % 8)];
            @(posedge CLK); #1;
        end
        chk("disabled_done", int'(o_done), 0);

        // Clean pattern: pass after sample 128
        fill_pattern(0);
        run(WIN + 10, 128, 1'b1);
        // No activity: fail at window end
        fill_const(1'b0);
        run(WIN + 10, WIN, 1'b0);
        // Broken 16th iteration: pass after iteration 32
        fill_pattern(0);
        s[128] = 1'b1;
        run(WIN + 10, 256, 1'b1);
        // Three-bit phase offset
        fill_pattern(3);
        run(WIN + 10, 131, 1'b1);
        // Abort after 10 matched iterations, then a fresh clean check
        fill_pattern(0);
        run(80, 128, 1'b1);
        run(WIN + 10, 128, 1'b1);
        // All-ones lane never matches
        fill_const(1'b1);
        run(WIN + 10, 0, 1'b0);

        // Randomized sessions checked against the model
        for (int r = 0; r < 10; r++) begin
            off = $urandom_range(0, 7);
            case (r % 4)
                0: begin
                    fill_pattern(off);
                    for (int i = 0; i < WIN / 8; i++)
                        if ($urandom_range(0, 9) == 0) begin
                            int pos;
                            pos = off + 8 * i + $urandom_range(1, 8);
                            if (pos <= WIN) s[pos] = ~s[pos];
                        end
                    run(WIN + 10, 0, 1'b0);
                end
                1: begin
                    for (int k = 1; k <= WIN; k++) s[k] = 1'($urandom);
                    run(WIN + 10, 0, 1'b0);
                end
                2: begin
                    fill_pattern(off);
                    run($urandom_range(1, 200), 0, 1'b0);
                end
                default: begin
                    // Every 3rd iteration broken: repeated re-lock, window expiry
                    fill_pattern(off);
                    for (int i = 2; i < WIN / 8; i += 3)
                        if (off + 8 * i + 8 <= WIN) s[off + 8 * i + 8] = 1'b1;
                    run(WIN + 10, 0, 1'b0);
                end
            endcase
        end

        repeat (4) @(posedge CLK);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
